alu_arb: RTL and testbench

ALU_ARB -- requirements
Module: alu_arb

---
 rtl/alu_arb_pkg.sv | 24 ++
 rtl/alu16_core.sv | 50 +++++
 rtl/alu_arb.sv | 138 +++++++++++++
 tb/tb_alu_arb.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared constants for the two-requester ALU arbiter.
// Holds the datapath width, the 3-bit operation-select encoding and the
// FSM state type used by alu_arb.
package alu_arb_pkg;

  localparam int DATA_W = 16;

  // Operation select encoding
  localparam logic [2:0] SEL_ADD  = 3'b000;  // A + B + Cin
  localparam logic [2:0] SEL_INC  = 3'b001;  // A + 1 + Cin
  localparam logic [2:0] SEL_SUB  = 3'b010;  // A + (~B + 1) + Cin
  localparam logic [2:0] SEL_DEC  = 3'b011;  // A + 0xFFFF + Cin
  localparam logic [2:0] SEL_AND  = 3'b100;
  localparam logic [2:0] SEL_OR   = 3'b101;
  localparam logic [2:0] SEL_XOR  = 3'b110;
  localparam logic [2:0] SEL_NAND = 3'b111;

  // FSM state encoding
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_EXEC = 2'd1;
  localparam state_t ST_RESP = 2'd2;

endpackage

// File: rtl/alu16_core.sv
// alu16_core: purely combinational 16-bit ALU.
// Arithmetic ops share one adder whose second operand is selected by SEL;
// logic ops bypass the adder and force cout to 0.
module alu16_core
  import alu_arb_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  input  logic [2:0]        sel,
  output logic [DATA_W-1:0] result,
  output logic              cout
);

  logic [DATA_W-1:0] b_op;
  logic [DATA_W:0]   sum;

  // Pick the adder's second operand. The subtract operand is the 16-bit
  // two's-complement negation of B (so B=0 contributes 0, not 0x10000).
  always_comb begin
    // NOTE: default assignment first so no path leaves b_op unassigned (no latch).
    b_op = '0;
    case (sel)
      SEL_ADD: b_op = b;
      SEL_INC: b_op = DATA_W'(1);
      SEL_SUB: b_op = ~b + DATA_W'(1);
      SEL_DEC: b_op = '1;
      default: b_op = '0;
    endcase
  end

  assign sum = {1'b0, a} + {1'b0, b_op} + (DATA_W + 1)'(cin);

  // Final result mux: logic ops or the adder output with its bit-16 carry.
  always_comb begin
    result = '0;
    cout   = 1'b0;
    case (sel)
      SEL_AND:  result = a & b;
      SEL_OR:   result = a | b;
      SEL_XOR:  result = a ^ b;
      SEL_NAND: result = ~(a & b);
      default: begin
        result = sum[DATA_W-1:0];
        cout   = sum[DATA_W];
      end
    endcase
  end

endmodule

// File: rtl/alu_arb.sv
// alu_arb: two requesters share one 16-bit ALU through a round-robin
// arbiter and an IDLE -> EXEC -> RESP sequencer (one op per 3 cycles max).
// Optional feature: define ALU_ARB_STATS_EN to add per-requester 16-bit
// request-handshake counters on ports stat_cnt0 / stat_cnt1.
module alu_arb
  import alu_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req0_cin,
  input  logic [2:0]        req0_sel,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic              req1_cin,
  input  logic [2:0]        req1_sel,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp0_cout,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp1_cout
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [DATA_W-1:0] stat_cnt0,
  output logic [DATA_W-1:0] stat_cnt1
`endif
);

  state_t            state;
  logic              owner;        // requester that owns the in-flight op
  logic              last_served;  // requester whose response completed last
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic              cin_q;
  logic [2:0]        sel_q;
  logic [DATA_W-1:0] result_q;
  logic              cout_q;
  logic [DATA_W-1:0] alu_result;
  logic              alu_cout;
  logic              grant_en;
  logic              grant_id;
  logic              in_resp;
  logic              rsp_hs;

  alu16_core u_core (
    .a      (a_q),
    .b      (b_q),
    .cin    (cin_q),
    .sel    (sel_q),
    .result (alu_result),
    .cout   (alu_cout)
  );

  // Round-robin grant: on contention the requester not served last wins.
  // Ready is held low while reset is asserted so nothing is accepted then.
  always_comb begin
    grant_id   = (req0_valid & req1_valid) ? ~last_served : req1_valid;
    grant_en   = rst_n & (state == ST_IDLE) & (req0_valid | req1_valid);
    req0_ready = grant_en & ~grant_id;
    req1_ready = grant_en & grant_id;
  end

  assign in_resp = (state == ST_RESP);
  assign rsp_hs  = in_resp & (owner ? rsp1_ready : rsp0_ready);

  // Responses are steered to the owner only; the other side reads zero.
  assign rsp0_valid  = in_resp & ~owner;
  assign rsp1_valid  = in_resp & owner;
  assign rsp0_result = rsp0_valid ? result_q : '0;
  assign rsp1_result = rsp1_valid ? result_q : '0;
  assign rsp0_cout   = rsp0_valid & cout_q;
  assign rsp1_cout   = rsp1_valid & cout_q;

  // Sequencer: latch the granted op, register the ALU result, hold it
  // until the owner takes it, then update the round-robin pointer.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all clocked state so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      state       <= ST_IDLE;
      owner       <= 1'b0;
      last_served <= 1'b1;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      sel_q       <= SEL_ADD;
      result_q    <= '0;
      cout_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_en) begin
            a_q   <= grant_id ? req1_a   : req0_a;
            b_q   <= grant_id ? req1_b   : req0_b;
            cin_q <= grant_id ? req1_cin : req0_cin;
            sel_q <= grant_id ? req1_sel : req0_sel;
            owner <= grant_id;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          result_q <= alu_result;
          cout_q   <= alu_cout;
          state    <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_hs) begin
            last_served <= owner;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU_ARB_STATS_EN
  // Per-requester accepted-request counters, wrapping naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_cnt0 <= '0;
      stat_cnt1 <= '0;
    end else begin
      if (req0_ready) stat_cnt0 <= stat_cnt0 + 1'b1;
      if (req1_ready) stat_cnt1 <= stat_cnt1 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arb.sv
// tb_alu_arb: self-checking bench for alu_arb. A transaction-level model
// (in-flight op with its accept cycle, last-served requester) predicts the
// outputs every cycle; directed scenarios pin the model with literal values.
// Build with ALU_ARB_STATS_EN defined to also check stat_cnt0 / stat_cnt1.
module tb_alu_arb;
  import alu_arb_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req0_valid, req0_ready, req0_cin;
  logic [15:0] req0_a, req0_b;
  logic [2:0]  req0_sel;
  logic        req1_valid, req1_ready, req1_cin;
  logic [15:0] req1_a, req1_b;
  logic [2:0]  req1_sel;
  logic        rsp0_valid, rsp0_ready, rsp0_cout;
  logic [15:0] rsp0_result;
  logic        rsp1_valid, rsp1_ready, rsp1_cout;
  logic [15:0] rsp1_result;
`ifdef ALU_ARB_STATS_EN
  logic [15:0] stat_cnt0, stat_cnt1;
`endif

  int checks   = 0;
  int failures = 0;

  alu_arb dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_cin    (req0_cin),
    .req0_sel    (req0_sel),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_cin    (req1_cin),
    .req1_sel    (req1_sel),
    .rsp0_valid  (rsp0_valid),
    .rsp0_ready  (rsp0_ready),
    .rsp0_result (rsp0_result),
    .rsp0_cout   (rsp0_cout),
    .rsp1_valid  (rsp1_valid),
    .rsp1_ready  (rsp1_ready),
    .rsp1_result (rsp1_result),
    .rsp1_cout   (rsp1_cout)
`ifdef ALU_ARB_STATS_EN
    ,
    .stat_cnt0   (stat_cnt0),
    .stat_cnt1   (stat_cnt1)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU in plain integer arithmetic; returns {cout, result}.
  function automatic logic [16:0] model_alu(input logic [15:0] a, input logic [15:0] b,
                                            input logic cin, input logic [2:0] sel);
    int unsigned ua, ub, s;
    ua = a;
    ub = b;
    s  = 0;
    case (sel)
      3'd0: s = ua + ub + cin;
      3'd1: s = ua + 1 + cin;
      3'd2: s = ua + ((65536 - ub) % 65536) + cin;
      3'd3: s = ua + 65535 + cin;
      3'd4: return {1'b0, a & b};
      3'd5: return {1'b0, a | b};
      3'd6: return {1'b0, a ^ b};
      default: return {1'b0, ~(a & b)};
    endcase
    return {(s >> 16) != 0, 16'(s)};
  endfunction

  // Transaction-level model state
  bit          m_known = 1'b0;
  bit          m_busy  = 1'b0;
  bit          m_owner = 1'b0;
  bit          m_last  = 1'b1;
  int          cyc     = 0;
  int          m_acc   = 0;
  logic [15:0] m_res   = '0;
  logic        m_cout  = 1'b0;
  logic [15:0] m_cnt0  = '0;
  logic [15:0] m_cnt1  = '0;

  // Compare process: predict this cycle's outputs, compare, then advance
  // the model by the clock edge that follows.
  always @(negedge clk) begin : compare
    logic resp_phase, winner, grant;
    logic [16:0] r;
    resp_phase = m_busy && (cyc >= m_acc + 2);
    winner     = (req0_valid && req1_valid) ? !m_last : req1_valid;
    grant      = m_known && !m_busy && rst_n && (req0_valid || req1_valid);
    if (m_known) begin
      check("req_ready", 64'({req0_ready, req1_ready}), 64'({grant && !winner, grant && winner}));
      check("rsp_valid", 64'({rsp0_valid, rsp1_valid}),
            64'({resp_phase && !m_owner, resp_phase && m_owner}));
      check("rsp0_data", 64'({rsp0_cout, rsp0_result}),
            64'((resp_phase && !m_owner) ? {m_cout, m_res} : 17'h0));
      check("rsp1_data", 64'({rsp1_cout, rsp1_result}),
            64'((resp_phase && m_owner) ? {m_cout, m_res} : 17'h0));
`ifdef ALU_ARB_STATS_EN
      check("stat_cnt", 64'({stat_cnt0, stat_cnt1}), 64'({m_cnt0, m_cnt1}));
`endif
    end
    if (!rst_n) begin
      m_known = 1'b1;
      m_busy  = 1'b0;
      m_last  = 1'b1;
      m_cnt0  = '0;
      m_cnt1  = '0;
    end else if (m_known) begin
      if (grant) begin
        r = winner ? model_alu(req1_a, req1_b, req1_cin, req1_sel)
                   : model_alu(req0_a, req0_b, req0_cin, req0_sel);
        {m_cout, m_res} = r;
        m_busy  = 1'b1;
        m_acc   = cyc;
        m_owner = winner;
        if (winner) m_cnt1 = m_cnt1 + 16'd1;
        else        m_cnt0 = m_cnt0 + 16'd1;
      end else if (resp_phase && (m_owner ? rsp1_ready : rsp0_ready)) begin
        m_busy = 1'b0;
        m_last = m_owner;
      end
    end
    cyc++;
  end

  task automatic set_req(input bit id, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic [2:0] sel);
    if (id) begin
      req1_a = a; req1_b = b; req1_cin = cin; req1_sel = sel; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_cin = cin; req0_sel = sel; req0_valid = 1'b1;
    end
  endtask

  // One isolated operation from an idle arbiter with literal expectations.
  task automatic directed_op(input string name, input bit id, input logic [15:0] a,
                             input logic [15:0] b, input logic cin, input logic [2:0] sel,
                             input logic [15:0] exp_res, input logic exp_cout);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    set_req(id, a, b, cin, sel);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    @(negedge clk);
    check({name, "_ready"}, 64'(id ? req1_ready : req0_ready), 64'(1));
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    check({name, "_exec_idle"}, 64'({rsp0_valid, rsp1_valid}), 64'(0));
    @(negedge clk);
    check({name, "_valid"}, 64'(id ? rsp1_valid : rsp0_valid), 64'(1));
    check({name, "_data"}, 64'(id ? {rsp1_cout, rsp1_result} : {rsp0_cout, rsp0_result}),
          64'({exp_cout, exp_res}));
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_cin = 1'b0; req0_sel = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0; req1_sel = '0;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("reset_ready", 64'({req0_ready, req1_ready}), 64'(0));
    check("reset_rsp", 64'({rsp0_valid, rsp1_valid, rsp0_cout, rsp1_cout, rsp0_result, rsp1_result}),
          64'(0));

    // Literal ALU cases
    directed_op("add",  1'b0, 16'h0003, 16'h0004, 1'b0, SEL_ADD, 16'h0007, 1'b0);
    directed_op("sub",  1'b0, 16'h0005, 16'h0007, 1'b0, SEL_SUB, 16'hFFFE, 1'b0);
    directed_op("inc",  1'b0, 16'hFFFF, 16'h0000, 1'b0, SEL_INC, 16'h0000, 1'b1);
`ifdef ALU_ARB_STATS_EN
    check("stat_cnt0_3", 64'(stat_cnt0), 64'(3));
`endif
    directed_op("nand", 1'b1, 16'hFF00, 16'h0FF0, 1'b0, SEL_NAND, 16'hF0FF, 1'b0);
    directed_op("addc", 1'b1, 16'h8000, 16'h8000, 1'b1, SEL_ADD, 16'h0001, 1'b1);
    directed_op("xor",  1'b1, 16'hAAAA, 16'hFFFF, 1'b1, SEL_XOR, 16'h5555, 1'b0);
    directed_op("dec",  1'b0, 16'h0001, 16'h1234, 1'b0, SEL_DEC, 16'h0000, 1'b1);

    // Reset during EXEC: op discarded, pointer back to favouring requester 0
    @(posedge clk); #1;
    set_req(1'b0, 16'h0101, 16'h0202, 1'b0, SEL_ADD);
    @(negedge clk);
    check("rst_exec_accept", 64'(req0_ready), 64'(1));
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_exec_no_rsp", 64'({rsp0_valid, rsp1_valid}), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_req(1'b0, 16'h0010, 16'h0020, 1'b0, SEL_OR);
    set_req(1'b1, 16'h0040, 16'h0080, 1'b0, SEL_OR);
    @(negedge clk);
    check("rst_exec_post_rsp", 64'({rsp0_valid, rsp1_valid}), 64'(0));
    check("rst_exec_grant0", 64'({req0_ready, req1_ready}), 64'(2'b10));
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_exec_new_rsp", 64'({rsp0_valid, rsp0_cout, rsp0_result}), 64'({2'b10, 16'h0030}));

    // Both requesters valid continuously: grants alternate 0,1,0,1
    pulse_reset();
    set_req(1'b0, 16'h1111, 16'h2222, 1'b0, SEL_ADD);
    set_req(1'b1, 16'h3333, 16'h0F0F, 1'b0, SEL_AND);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("rr_grant%0d", i), 64'({req0_ready, req1_ready}),
            64'((i % 2 == 0) ? 2'b10 : 2'b01));
      repeat (2) @(negedge clk);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (3) @(posedge clk);

    // Response backpressure: result holds, requester 1 waits for handshake
    pulse_reset();
    set_req(1'b0, 16'h1234, 16'h1111, 1'b0, SEL_ADD);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b1;
    @(negedge clk);
    check("bp_accept0", 64'(req0_ready), 64'(1));
    @(posedge clk); #1;
    req0_valid = 1'b0;
    set_req(1'b1, 16'h0100, 16'h0001, 1'b0, SEL_ADD);
    @(negedge clk);
    check("bp_exec_ready1", 64'(req1_ready), 64'(0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold%0d", i), 64'({rsp0_valid, req1_ready, rsp0_cout, rsp0_result}),
            64'({3'b100, 16'h2345}));
    end
    @(posedge clk); #1;
    rsp0_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_cycle", 64'({rsp0_valid, req1_ready}), 64'(2'b10));
    @(negedge clk);
    check("bp_grant1", 64'({req0_ready, req1_ready}), 64'(2'b01));
    @(posedge clk); #1;
    req1_valid = 1'b0;
    repeat (3) @(posedge clk);

    // Randomized traffic checked by the model every cycle
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      rst_n      = ($urandom_range(0, 149) != 0);
      req0_valid = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 2) != 0);
      req0_a     = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      req0_b     = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      req1_a     = 16'($urandom);
      req1_b     = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      req0_cin   = 1'($urandom);
      req1_cin   = 1'($urandom);
      req0_sel   = 3'($urandom);
      req1_sel   = 3'($urandom);
      rsp0_ready = ($urandom_range(0, 3) != 0);
      rsp1_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
